// File: rtl/idct_pkg.sv
// Shared constants and the bank/counter address helper for the IDCT transpose buffer.
package idct_pkg;

    localparam int BLK_N           = 8;
    localparam int BLK_SZ          = BLK_N * BLK_N;
    localparam int WIDTH_X_DEFAULT = 16;
    localparam int ADDR_W          = 7;
    localparam int CNT_W           = 6;

    // With transpose set, the row and column fields of cnt swap places.
    function automatic logic [ADDR_W-1:0] tp_addr(input logic bank,
                                                  input logic [CNT_W-1:0] cnt,
                                                  input logic transpose);
        logic [ADDR_W-1:0] addr;
        if (transpose)
            addr = {bank, cnt[2:0], cnt[5:3]};
        else
            addr = {bank, cnt};
        return addr;
    endfunction

endpackage

// File: rtl/tp_dpram.sv
// Two-bank sample store: synchronous write port, registered read port that resets to zero.
module tp_dpram
    import idct_pkg::*;
#(
    parameter int WIDTH_X = WIDTH_X_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [WIDTH_X-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [WIDTH_X-1:0] rdata
);

    localparam int DEPTH = 2 * BLK_SZ;

    logic [WIDTH_X-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // The read register doubles as the block's output data register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: row-major samples in, column-major samples out.
module idct_transpose_buf
    import idct_pkg::*;
#(
    parameter int WIDTH_X = WIDTH_X_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_X-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_X-1:0] out_data,
    output logic               out_last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_SZ - 1);

    logic             wbank, rbank;
    logic [CNT_W-1:0] wcnt, rcnt;
    logic [1:0]       full, full_next;
    logic             wr, rd, wr_end, rd_end;

    assign in_ready = rst_n && !full[wbank];
    assign wr       = in_valid && in_ready;
    assign rd       = full[rbank] && (!out_valid || out_ready);
    assign wr_end   = wr && (wcnt == CNT_LAST);
    assign rd_end   = rd && (rcnt == CNT_LAST);

    // Fill and drain always target different banks, so set and clear never collide.
    always_comb begin
        full_next = full;
        if (wr_end)
            full_next[wbank] = 1'b1;
        if (rd_end)
            full_next[rbank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
            full  <= 2'b00;
        end else begin
            if (wr) begin
                wcnt <= wcnt + 1'b1;
                if (wr_end)
                    wbank <= ~wbank;
            end
            if (rd) begin
                rcnt <= rcnt + 1'b1;
                if (rd_end)
                    rbank <= ~rbank;
            end
            full <= full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (rd) begin
            out_valid <= 1'b1;
            out_last  <= (rcnt == CNT_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    tp_dpram #(
        .WIDTH_X(WIDTH_X)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr),
        .waddr (tp_addr(wbank, wcnt, 1'b0)),
        .wdata (in_data),
        .re    (rd),
        .raddr (tp_addr(rbank, rcnt, 1'b1)),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Randomized and directed bench for idct_transpose_buf against a block-level transpose model.
module tb_idct_transpose_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    idct_transpose_buf #(
        .WIDTH_X(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: complete blocks become a queue of transposed samples.
    logic [15:0] blk [64];
    int          wr_cnt = 0;
    logic [15:0] exp_q [$];
    bit          exp_last_q [$];

    int  accepted, out_seen, gap_cnt, ready_low_cnt;
    int  first_valid_cyc, last_write_cyc;
    bit  seen_valid, hold_pending, last_in_ready;
    logic [15:0] held_data;
    logic        held_last;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic start_test();
        accepted        = 0;
        out_seen        = 0;
        gap_cnt         = 0;
        ready_low_cnt   = 0;
        first_valid_cyc = -1;
        last_write_cyc  = -1;
        seen_valid      = 0;
    endtask

    // Drive one cycle of inputs, observe mid-cycle, and update the model.
    task automatic applyStimulus(input logic iv, input logic [15:0] id, input logic ordy);
        logic        wr_hs, rd_hs;
        logic [15:0] e;
        bit          el;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            wr_cnt = 0;
            exp_q.delete();
            exp_last_q.delete();
            hold_pending = 0;
        end else begin
            wr_hs = in_valid && in_ready;
            rd_hs = out_valid && out_ready;
            last_in_ready = in_ready;
            if (!in_ready)
                ready_low_cnt++;
            if (hold_pending) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, held_data);
                checkOutput("hold_last", out_last, held_last);
            end
            if (out_valid && !seen_valid) begin
                seen_valid      = 1;
                first_valid_cyc = cyc;
            end
            if (seen_valid && !out_valid && exp_q.size() > 0)
                gap_cnt++;
            if (rd_hs) begin
                checkOutput("out_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    checkOutput("out_data", out_data, e);
                    checkOutput("out_last", out_last, el);
                    out_seen++;
                end
            end
            if (wr_hs) begin
                blk[wr_cnt] = in_data;
                wr_cnt++;
                accepted++;
                if (wr_cnt == 64) begin
                    last_write_cyc = cyc;
                    for (int k = 0; k < 64; k++) begin
                        exp_q.push_back(blk[(k % 8) * 8 + k / 8]);
                        exp_last_q.push_back(k == 63);
                    end
                    wr_cnt = 0;
                end
            end
            hold_pending = out_valid && !out_ready;
            held_data    = out_data;
            held_last    = out_last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit rand_ready);
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0 && !out_valid)
                break;
            applyStimulus(1'b0, 16'h0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        checkOutput("drain_empty", exp_q.size(), 0);
        checkOutput("drain_idle", out_valid, 0);
    endtask

    initial begin
        int ret_idx;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Single ramp block: latency and transposed order
        start_test();
        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, 16'(i), 1'b1);
        checkOutput("ramp_accepted", accepted, 64);
        drain(0);
        checkOutput("ramp_out_count", out_seen, 64);
        checkOutput("ramp_latency", first_valid_cyc, last_write_cyc + 2);

        // Three back-to-back ramp blocks at full rate
        start_test();
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++)
                applyStimulus(1'b1, 16'(b * 100 + i), 1'b1);
        drain(0);
        checkOutput("b2b_accepted", accepted, 192);
        checkOutput("b2b_ready_low", ready_low_cnt, 0);
        checkOutput("b2b_out_count", out_seen, 192);
        checkOutput("b2b_gaps", gap_cnt, 0);

        // Backpressure: both banks fill, then release
        start_test();
        for (int i = 0; i < 200; i++) begin
            if (!in_ready)
                break;
            applyStimulus(1'b1, 16'($urandom), 1'b0);
        end
        checkOutput("bp_capacity", accepted, 128);
        ret_idx = -1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 16'($urandom), 1'b1);
            if (last_in_ready) begin
                ret_idx = i;
                break;
            end
        end
        checkOutput("bp_ready_return", ret_idx, 63);
        for (int i = 0; i < 200; i++) begin
            if (wr_cnt == 0)
                break;
            applyStimulus(1'b1, 16'($urandom), 1'b1);
        end
        drain(0);
        checkOutput("bp_out_count", out_seen, accepted);

        // Random valid/ready toggling over two blocks
        start_test();
        for (int i = 0; i < 3000; i++) begin
            if (accepted >= 128)
                break;
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        drain(1);
        checkOutput("rand_accepted", accepted, 128);
        checkOutput("rand_out_count", out_seen, 128);

        // Signed extremes
        start_test();
        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, (i % 2 == 0) ? 16'h8000 : 16'h7fff, 1'b1);
        drain(0);
        checkOutput("ext_out_count", out_seen, 64);

        // Reset in the middle of draining a block
        start_test();
        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, 16'(i), 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (out_seen >= 20)
                break;
            applyStimulus(1'b0, 16'h0, 1'b1);
        end
        checkOutput("mid_out_count", out_seen, 20);
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_data", out_data, 0);
        checkOutput("mid_rst_out_last", out_last, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        start_test();
        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, 16'(i), 1'b1);
        drain(0);
        checkOutput("after_rst_out_count", out_seen, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idct_transpose_buf.md
# idct_transpose_buf

Ping-pong 8x8 transpose buffer between the row-pass and column-pass 1-D IDCT stages. It accepts the row stage's results as a valid/ready stream in row-major order, 64 signed samples per block, and returns each block column-major to the column stage. Two 64-entry banks let block N+1 fill while block N drains, so both sides sustain one sample per cycle.

## Interface
- WIDTH_X, 16: sample width, two's complement.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- in_valid  in  1  row-stage sample valid.
- in_ready  out  1  buffer can accept the sample; 0 while rst_n=0.
- in_data  in  WIDTH_X  signed sample, row-major within the block.
- out_valid  out  1  out_data holds a valid sample.
- out_ready  in  1  column stage accepts the sample.
- out_data  out  WIDTH_X  signed sample, column-major within the block.
- out_last  out  1  marks the 64th sample of a block; qualified by out_valid.

## Operation
- State: wbank, rbank (1 bit each); wcnt, rcnt (6 bits each); full[1:0].
- Write handshake: in_valid && in_ready.
  - Each write goes to address {wbank, wcnt}, with row = wcnt[5:3] and col = wcnt[2:0].
  - wcnt increments on every write.
  - On a write with wcnt=63: set full[wbank], toggle wbank, wrap wcnt to 0.
- in_ready = rst_n && !full[wbank].
- Read issue: rd = full[rbank] && (!out_valid || out_ready).
  - Read address is {rbank, rcnt[2:0], rcnt[5:3]}. Output k is therefore element (row k%8, col k/8).
  - On each rd, rcnt increments.
  - On rd with rcnt=63: clear full[rbank], toggle rbank, wrap rcnt to 0.
- Output register:
  - On rd: out_data <= ram, out_valid <= 1, out_last <= (rcnt==63).
  - Else if out_ready: out_valid <= 0 and out_last <= 0. out_data holds its value.
  - Else: all outputs hold.
- Arithmetic: samples are stored and returned bit-exact, with no saturation or rescaling.
- Boundary conditions:
  - Both banks full: in_ready=0, and input stalls until the 64th read of rbank is issued. The freed bank accepts writes from the next cycle.
  - Write to one bank and read from the other in the same cycle: both proceed.
  - A bank is never written and read in the same cycle. full[] prevents it.
  - out_valid && !out_ready: out_data and out_last hold stable.
- Reset, synchronous, at any point including mid-block:
  - wbank=rbank=0, wcnt=rcnt=0, full=2'b00.
  - out_valid=0, out_data=0, out_last=0.
  - RAM contents are not cleared.
  - Partial blocks are discarded. The next accepted sample is element (0,0) of a new block.

## Timing
- The RAM has a 1-cycle registered read, and the output register is the RAM read register.
- Latency: if the 64th write handshake is in cycle t, out_valid first rises in cycle t+2 with element (0,0). This applies when the read bank is idle.
- Throughput with out_ready=1 and continuous in_valid:
  - in_ready never deasserts.
  - out_valid stays high continuously from the first output onward.
- Capacity: 128 samples are accepted with out_ready=0 before in_ready falls.
- Every output changes on the clk rising edge. in_ready is combinational from the registered full[] flags and rst_n.

## Structure
- Package idct_pkg holds:
  - BLK_N=8 and BLK_SZ=64.
  - Default WIDTH_X.
  - The address helper function tp_addr(bank, cnt, transpose).
- Sub-module tp_dpram: 128 x WIDTH_X simple dual-port RAM.
  - Synchronous write, with we and 7-bit waddr.
  - Synchronous read, with re and 7-bit raddr.
  - Output register resets to 0 on rst_n=0 and holds when re=0.
- Top level contains the counters, the full[] flags, the handshake logic and out_valid/out_last.

## Test plan
- Single block, ramp: in_data = 0..63, out_ready=1.
  - Outputs are 0,8,16,…,56,1,9,…,63.
  - out_last is high only on 63.
  - First out_valid is in cycle t+2.
- Back-to-back blocks: three ramp blocks with offsets 0/100/200, continuous in_valid, out_ready=1.
  - in_ready is never 0.
  - 192 outputs appear contiguously in transposed order.
- Backpressure: out_ready=0, in_valid continuous.
  - in_ready falls after exactly 128 writes.
  - After out_ready rises, in_ready returns the cycle after the 64th read of block 0.
  - No samples are lost.
- Random out_ready toggling: out_data and out_last stay stable while out_valid && !out_ready, and the full sequence is correct.
- Signed extremes: block of alternating -32768/32767 (WIDTH_X=16) is returned bit-exact after transpose.
- Reset mid-drain: rst_n=0 for one cycle at output 20.
  - out_valid=0, out_data=0, out_last=0, in_ready=1 after release.
  - A new ramp block then emerges starting at 0.
